// File: rtl/regfile_pkg.sv
// ============================================================================
// Module  : regfile_pkg
// Purpose : Shared register-file constants, write-entry type and lane popcount.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package regfile_pkg;

  localparam int PHYS_REGS = 64;
  localparam int TAG_W     = 6;
  localparam int DATA_W    = 32;
  localparam int N_LANES   = 4;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } reg_write_t;

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

endpackage

`default_nettype wire

// File: rtl/lane_compactor.sv
// ============================================================================
// Module  : lane_compactor
// Purpose : Packs valid execution lanes into consecutive slots, oldest first.
//           Build option REG_WRITE_P0_FILTER_EN drops lanes targeting tag 0.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module lane_compactor
  import regfile_pkg::*;
(
  input  logic [N_LANES-1:0]           i_vec,
  input  logic [N_LANES*TAG_W-1:0]     i_tag,
  input  logic [N_LANES*DATA_W-1:0]    i_data,
  output reg_write_t [N_LANES-1:0]     o_ent,
  output logic [2:0]                   o_cnt
);

  logic [N_LANES-1:0] w_keep;
  logic [1:0]         w_slot;

  always_comb begin
    w_keep = i_vec;
`ifdef REG_WRITE_P0_FILTER_EN
    // p0 is not hard-wired to zero in the file, so writes to it must never land
    for (int k = 0; k < N_LANES; k++) begin
      if (i_tag[k*TAG_W +: TAG_W] == '0) w_keep[k] = 1'b0;
    end
`endif
  end

  always_comb begin
    o_ent  = '0;
    w_slot = '0;
    for (int k = 0; k < N_LANES; k++) begin
      if (w_keep[k]) begin
        o_ent[w_slot].tag  = i_tag[k*TAG_W +: TAG_W];
        o_ent[w_slot].data = i_data[k*DATA_W +: DATA_W];
        w_slot             = w_slot + 2'd1;
      end
    end
  end

  assign o_cnt = popcount4(w_keep);

endmodule

`default_nettype wire

// File: rtl/reg_write_queue.sv
// ============================================================================
// Module  : reg_write_queue
// Purpose : FIFO of completed results draining up to N_WRITE register-file
//           writes per cycle. Build option REG_WRITE_P0_FILTER_EN drops tag 0.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_write_queue #(
  parameter int DEPTH   = 16,
  parameter int N_WRITE = 4,
  parameter int TAG_W   = 6
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic [3:0]               pushVec,
  input  logic [4*TAG_W-1:0]       pushTag,
  input  logic [127:0]             pushData,
  output logic                     inReady,
  input  logic                     drainEn,
  output logic                     commitAllow,
  output logic [0:3]               commitVec,
  output logic [TAG_W-1:0]         writeSelect0,
  output logic [TAG_W-1:0]         writeSelect1,
  output logic [TAG_W-1:0]         writeSelect2,
  output logic [TAG_W-1:0]         writeSelect3,
  output logic [31:0]              writeData0,
  output logic [31:0]              writeData1,
  output logic [31:0]              writeData2,
  output logic [31:0]              writeData3,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflowErr
);

  import regfile_pkg::*;

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]       r_head;
  logic [PW-1:0]       r_tail;
  logic [CW-1:0]       r_count;
  logic                r_ovf;
  logic [TAG_W-1:0]    r_tag  [DEPTH];
  logic [31:0]         r_data [DEPTH];

  logic                r_allow;
  logic [0:3]          r_vec;
  logic [TAG_W-1:0]    r_sel [4];
  logic [31:0]         r_dat [4];

  reg_write_t [3:0]    w_ent;
  logic [2:0]          w_n_in;
  logic                w_push_ok;
  logic [2:0]          w_n_push;
  logic [2:0]          w_n_pop;

  lane_compactor u_compact (
    .i_vec  (pushVec),
    .i_tag  (pushTag),
    .i_data (pushData),
    .o_ent  (w_ent),
    .o_cnt  (w_n_in)
  );

  assign inReady   = (r_count <= CW'(DEPTH - 4));
  assign w_push_ok = en && inReady;
  assign w_n_push  = w_push_ok ? w_n_in : 3'd0;

  // Pop decisions use only the pre-edge occupancy, so same-cycle pushes are invisible
  always_comb begin
    w_n_pop = 3'd0;
    if (en && drainEn) begin
      if (r_count >= CW'(N_WRITE)) w_n_pop = 3'(N_WRITE);
      else                         w_n_pop = r_count[2:0];
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (3'(k) < w_n_push) begin
        r_tag[r_tail + PW'(k)]  <= w_ent[k].tag;
        r_data[r_tail + PW'(k)] <= w_ent[k].data;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_head  <= r_head + PW'(w_n_pop);
      r_tail  <= r_tail + PW'(w_n_push);
      r_count <= r_count + CW'(w_n_push) - CW'(w_n_pop);
      if (en && !inReady && (pushVec != 4'd0)) r_ovf <= 1'b1;
    end
  end

  // Idle cycles clear the valid bits but leave select/data untouched
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_allow <= 1'b0;
      r_vec   <= '0;
      for (int i = 0; i < 4; i++) begin
        r_sel[i] <= '0;
        r_dat[i] <= '0;
      end
    end else if (en) begin
      r_allow <= (w_n_pop != 3'd0);
      if (w_n_pop == 3'd0) begin
        r_vec <= '0;
      end else begin
        for (int i = 0; i < 4; i++) begin
          if (3'(i) < w_n_pop) begin
            r_vec[i] <= 1'b1;
            r_sel[i] <= r_tag[r_head + PW'(i)];
            r_dat[i] <= r_data[r_head + PW'(i)];
          end else begin
            r_vec[i] <= 1'b0;
            r_sel[i] <= '0;
            r_dat[i] <= '0;
          end
        end
      end
    end
  end

  assign commitAllow  = r_allow;
  assign commitVec    = r_vec;
  assign writeSelect0 = r_sel[0];
  assign writeSelect1 = r_sel[1];
  assign writeSelect2 = r_sel[2];
  assign writeSelect3 = r_sel[3];
  assign writeData0   = r_dat[0];
  assign writeData1   = r_dat[1];
  assign writeData2   = r_dat[2];
  assign writeData3   = r_dat[3];
  assign count        = r_count;
  assign overflowErr  = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_reg_write_queue.sv
// ============================================================================
// Module  : tb_reg_write_queue
// Purpose : Self-checking bench for reg_write_queue against a queue model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_write_queue;

  localparam int DEPTH = 16;
  localparam int NW    = 4;
  localparam int TW    = 6;

  typedef logic [163:0] snap_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          en = 1'b0;
  logic [3:0]    pushVec = '0;
  logic [23:0]   pushTag = '0;
  logic [127:0]  pushData = '0;
  logic          drainEn = 1'b0;
  logic          inReady, commitAllow, overflowErr;
  logic [0:3]    commitVec;
  logic [TW-1:0] writeSelect0, writeSelect1, writeSelect2, writeSelect3;
  logic [31:0]   writeData0, writeData1, writeData2, writeData3;
  logic [4:0]    count;

  int checks = 0;
  int errors = 0;

  logic [5:0]  q_tag[$];
  logic [31:0] q_dat[$];
  logic [0:3]  m_vec;
  logic [5:0]  m_sel[4];
  logic [31:0] m_dat[4];
  logic        m_ovf;

  reg_write_queue #(.DEPTH(DEPTH), .N_WRITE(NW), .TAG_W(TW)) dut (
    .clk(clk), .reset(reset), .en(en), .pushVec(pushVec), .pushTag(pushTag),
    .pushData(pushData), .inReady(inReady), .drainEn(drainEn),
    .commitAllow(commitAllow), .commitVec(commitVec),
    .writeSelect0(writeSelect0), .writeSelect1(writeSelect1),
    .writeSelect2(writeSelect2), .writeSelect3(writeSelect3),
    .writeData0(writeData0), .writeData1(writeData1),
    .writeData2(writeData2), .writeData3(writeData3),
    .count(count), .overflowErr(overflowErr)
  );

  always #5 clk = ~clk;

  function automatic snap_t obs();
    return {commitAllow, commitVec, writeSelect0, writeSelect1, writeSelect2, writeSelect3,
            writeData0, writeData1, writeData2, writeData3, count, inReady, overflowErr};
  endfunction

  function automatic snap_t expct();
    return {|m_vec, m_vec, m_sel[0], m_sel[1], m_sel[2], m_sel[3],
            m_dat[0], m_dat[1], m_dat[2], m_dat[3], 5'(q_tag.size()),
            (q_tag.size() <= DEPTH - 4), m_ovf};
  endfunction

  function automatic void model_clear();
    q_tag.delete();
    q_dat.delete();
    m_vec = '0;
    m_ovf = 1'b0;
    for (int i = 0; i < 4; i++) begin
      m_sel[i] = '0;
      m_dat[i] = '0;
    end
  endfunction

  function automatic bit lane_kept(input logic [5:0] t);
`ifdef REG_WRITE_P0_FILTER_EN
    return t != 6'd0;
`else
    return 1'b1;
`endif
  endfunction

  // One clock edge of the queue, stated as list operations on the model
  function automatic void model_edge();
    int  p;
    bit  ready;
    if (!en) return;
    ready = (q_tag.size() <= DEPTH - 4);
    p = drainEn ? ((q_tag.size() < NW) ? q_tag.size() : NW) : 0;
    if (p == 0) begin
      m_vec = '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (i < p) begin
          m_vec[i] = 1'b1;
          m_sel[i] = q_tag.pop_front();
          m_dat[i] = q_dat.pop_front();
        end else begin
          m_vec[i] = 1'b0;
          m_sel[i] = '0;
          m_dat[i] = '0;
        end
      end
    end
    if (ready) begin
      for (int k = 0; k < 4; k++) begin
        if (pushVec[k] && lane_kept(pushTag[k*6 +: 6])) begin
          q_tag.push_back(pushTag[k*6 +: 6]);
          q_dat.push_back(pushData[k*32 +: 32]);
        end
      end
    end else if (pushVec != 4'd0) begin
      m_ovf = 1'b1;
    end
  endfunction

  task automatic step(input logic e, input logic [3:0] v, input logic [23:0] t,
                      input logic [127:0] d, input logic dr);
    en = e; pushVec = v; pushTag = t; pushData = d; drainEn = dr;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    en = 1'b0; pushVec = '0; drainEn = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (obs() !== expct()) begin
      errors++;
      $display("FAIL reset_state: got %h expected %h", obs(), expct());
    end
    reset = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    for (int c = 0; c < 5; c++) begin
      step(1'b1, 4'd0, '0, '0, 1'b1);
      checks++;
      if ({commitAllow, count, overflowErr, inReady} !== 8'b0000_0001) begin
        errors++;
        $display("FAIL idle_after_reset: got %b expected %b",
                 {commitAllow, count, overflowErr, inReady}, 8'b0000_0001);
      end
    end
  endtask

  task automatic test_single();
    step(1'b1, 4'b0100, {6'd0, 6'd5, 6'd0, 6'd0}, {32'd0, 32'hDEADBEEF, 64'd0}, 1'b1);
    checks++;
    if ({commitVec, count} !== {4'b0000, 5'd1}) begin
      errors++;
      $display("FAIL single_push: got vec=%b count=%0d expected vec=0000 count=1", commitVec, count);
    end
    step(1'b1, 4'd0, '0, '0, 1'b1);
    checks++;
    if ({commitAllow, commitVec, writeSelect0, writeData0, count} !==
        {1'b1, 4'b1000, 6'd5, 32'hDEADBEEF, 5'd0}) begin
      errors++;
      $display("FAIL single_write: got vec=%b sel0=%0d data0=%h count=%0d expected vec=1000 sel0=5 data0=deadbeef count=0",
               commitVec, writeSelect0, writeData0, count);
    end
    step(1'b1, 4'd0, '0, '0, 1'b1);
    checks++;
    if (obs() !== expct()) begin
      errors++;
      $display("FAIL single_idle: got %h expected %h", obs(), expct());
    end
  endtask

  task automatic test_burst();
    logic [23:0]  t;
    logic [127:0] d;
    for (int g = 0; g < 3; g++) begin
      for (int k = 0; k < 4; k++) begin
        t[k*6 +: 6]   = 6'(g*4 + k + 1);
        d[k*32 +: 32] = 32'h1000 + 32'(g*4 + k);
      end
      step(1'b1, 4'b1111, t, d, 1'b0);
      checks++;
      if (obs() !== expct()) begin
        errors++;
        $display("FAIL burst_fill: got %h expected %h", obs(), expct());
      end
    end
    checks++;
    if ({count, inReady} !== {5'd12, 1'b1}) begin
      errors++;
      $display("FAIL burst_count12: got count=%0d ready=%b expected 12 1", count, inReady);
    end
    step(1'b1, 4'b0001, {18'd0, 6'd13}, {96'd0, 32'h100C}, 1'b0);
    checks++;
    if ({count, inReady} !== {5'd13, 1'b0}) begin
      errors++;
      $display("FAIL burst_count13: got count=%0d ready=%b expected 13 0", count, inReady);
    end
    step(1'b1, 4'd0, '0, '0, 1'b1);
    checks++;
    if ({commitVec, writeSelect0, writeSelect1, writeSelect2, writeSelect3} !==
        {4'b1111, 6'd1, 6'd2, 6'd3, 6'd4}) begin
      errors++;
      $display("FAIL burst_first_drain: got vec=%b tags=%0d,%0d,%0d,%0d expected 1111 1,2,3,4",
               commitVec, writeSelect0, writeSelect1, writeSelect2, writeSelect3);
    end
    for (int c = 0; c < 4; c++) begin
      step(1'b1, 4'd0, '0, '0, 1'b1);
      checks++;
      if (obs() !== expct()) begin
        errors++;
        $display("FAIL burst_drain: got %h expected %h", obs(), expct());
      end
    end
  endtask

  task automatic test_overflow();
    logic [23:0]  t;
    logic [127:0] d;
    for (int g = 0; g < 4; g++) begin
      for (int k = 0; k < 4; k++) begin
        t[k*6 +: 6]   = 6'(20 + g*4 + k);
        d[k*32 +: 32] = 32'hA000 + 32'(g*4 + k);
      end
      step(1'b1, 4'b1111, t, d, 1'b0);
    end
    checks++;
    if ({count, inReady, overflowErr} !== {5'd16, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL ovf_full: got count=%0d ready=%b err=%b expected 16 0 0", count, inReady, overflowErr);
    end
    step(1'b1, 4'b0001, {18'd0, 6'd63}, {96'd0, 32'hBAD0BAD0}, 1'b0);
    checks++;
    if ({count, overflowErr} !== {5'd16, 1'b1}) begin
      errors++;
      $display("FAIL ovf_reject: got count=%0d err=%b expected 16 1", count, overflowErr);
    end
    for (int c = 0; c < 6; c++) begin
      step(1'b1, 4'd0, '0, '0, 1'b1);
      checks++;
      if (obs() !== expct()) begin
        errors++;
        $display("FAIL ovf_drain: got %h expected %h", obs(), expct());
      end
    end
    checks++;
    if (overflowErr !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sticky: got %b expected 1", overflowErr);
    end
    step(1'b1, 4'b0011, {12'd0, 6'd2, 6'd1}, {64'd0, 32'h22, 32'h11}, 1'b0);
    apply_reset();
  endtask

  task automatic test_filter();
    step(1'b1, 4'b1111, {6'd9, 6'd0, 6'd7, 6'd0}, {32'h9, 32'h0, 32'h7, 32'h0}, 1'b0);
    checks++;
`ifdef REG_WRITE_P0_FILTER_EN
    if (count !== 5'd2) begin
      errors++;
      $display("FAIL filter_count: got %0d expected 2", count);
    end
`else
    if (count !== 5'd4) begin
      errors++;
      $display("FAIL filter_count: got %0d expected 4", count);
    end
`endif
    for (int c = 0; c < 3; c++) begin
      step(1'b1, 4'd0, '0, '0, 1'b1);
      checks++;
      if (obs() !== expct()) begin
        errors++;
        $display("FAIL filter_drain: got %h expected %h", obs(), expct());
      end
    end
  endtask

  task automatic test_random();
    logic [3:0]   v;
    logic [23:0]  t;
    logic [127:0] d;
    logic         e, dr;
    int           seq = 0;
    int           budget;
    for (int c = 0; c < 80; c++) begin
      e  = ($urandom_range(0, 7) != 0);
      dr = ($urandom_range(0, 2) != 0);
      v  = (q_tag.size() <= DEPTH - 4) ? 4'($urandom_range(0, 15)) : 4'd0;
      for (int k = 0; k < 4; k++) begin
        t[k*6 +: 6]   = 6'($urandom_range(0, 63));
        d[k*32 +: 32] = 32'h5000_0000 + 32'(seq);
        seq++;
      end
      step(e, v, t, d, dr);
      checks++;
      if (obs() !== expct()) begin
        errors++;
        $display("FAIL random_cycle%0d: got %h expected %h", c, obs(), expct());
      end
    end
    budget = 0;
    while (q_tag.size() != 0 && budget < 10) begin
      step(1'b1, 4'd0, '0, '0, 1'b1);
      budget++;
    end
    step(1'b1, 4'd0, '0, '0, 1'b1);
    checks++;
    if (obs() !== expct() || count !== 5'd0) begin
      errors++;
      $display("FAIL random_final: got %h expected %h", obs(), expct());
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_single();
    test_burst();
    test_overflow();
    test_filter();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/reg_write_queue.md
Name: reg_write_queue

Overview:
- Writer side of the 64-entry physical register file write/commit interface.
- Buffers completed results (physical tag + 32-bit data) arriving from up to 4 execution lanes per cycle.
- Drains them oldest-first, up to N_WRITE per cycle, onto the register file's commitAllow / commitVec / writeSelectN / writeDataN ports.
- All write-side outputs are registered.

Parameters:
- DEPTH, 16, queue entries; power of two, ≥ 8.
- N_WRITE, 4, maximum writes issued per cycle (1..4); must equal the register file's N_WRITE.
- TAG_W, 6, physical register tag width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous active-low reset; 0 = reset.
- en  in  1  global enable; when 0, no push, no pop, and registered outputs hold.
- pushVec  in  4  per-lane result valid; bit 0 = oldest lane.
- pushTag  in  4*TAG_W  lane tags; lane k at [k*TAG_W +: TAG_W].
- pushData  in  128  lane data; lane k at [k*32 +: 32].
- inReady  out  1  combinational; 1 when free slots ≥ 4.
- drainEn  in  1  permission to issue writes this cycle.
- commitAllow  out  1  registered; 1 when any commitVec bit is set.
- commitVec  out  4  registered; [0:3] ordering; bit i valid for write port i.
- writeSelect0..3  out  TAG_W each  registered tags for write ports 0..3.
- writeData0..3  out  32 each  registered data for write ports 0..3.
- count  out  $clog2(DEPTH)+1  current occupancy.
- overflowErr  out  1  sticky; set when a push is attempted while inReady=0.

Behaviour:
- Reset (async, reset=0): head=tail=0, count=0, commitAllow=0, commitVec=0, writeSelect*=0, writeData*=0, overflowErr=0. Entry storage is not reset.
- Push, when en=1 and inReady=1:
  - Lanes with pushVec set are compacted in lane order and written at tail, tail+1, …
  - tail advances by popcount(pushVec), modulo DEPTH.
  - Wrap-around is by pointer arithmetic; pointers are $clog2(DEPTH) bits.
- Rejected push: en=1, inReady=0 and pushVec≠0 means the whole group is dropped and overflowErr is set. This is a protocol violation by the producer.
- Pop: each cycle with en=1, P = drainEn ? min(count, N_WRITE) : 0.
  - Entries head..head+P-1 load into write ports 0..P-1.
  - commitVec = lower P bits set; ports ≥ P get commitVec bit 0 and select/data 0.
  - head advances by P.
- When en=1 and P=0: commitAllow=0 and commitVec=0 on the next cycle. Select/data registers hold.
- Simultaneous push and pop: count_next = count + pushed − P. A pop never sees entries pushed in the same cycle.
- Latency:
  - Result pushed at edge t is counted after t.
  - Earliest pop decision is at edge t+1; the write appears on the ports after t+1.
  - The register file stores it at t+2.
- Ordering: writes are strictly FIFO. Two writes to the same tag in one cycle keep queue order on ports 0..3; lower-index port = older. The register file must give the higher index priority, which its sequential assignment order does.
- Full: count=DEPTH ⇒ inReady=0.
- Empty: count=0 ⇒ no pop, commitAllow=0.
- Reset asserted mid-operation discards all queued entries immediately.

Optional Feature:
- Macro: REG_WRITE_P0_FILTER_EN.
- Defined: lanes with tag 0 are dropped before compaction. They do not occupy slots and never reach the register file, because p0 is not held at 0 physically.
- Undefined: tag 0 is queued and written like any other tag.

Decomposition:
- Shared package regfile_pkg:
  - PHYS_REGS=64, TAG_W=6, DATA_W=32, N_LANES=4.
  - typedef reg_write_t {tag, data}.
  - popcount4 function.
- One natural sub-module, lane_compactor: a combinational 4-lane pack with optional p0 filter. It outputs the packed entries and the count.

Test Plan:
- Reset then idle: hold reset=0 for 3 cycles, release, drainEn=1 for 5 cycles → commitAllow=0, count=0, overflowErr=0, inReady=1 throughout.
- Single write latency: at edge t push lane 2 {tag 5, 0xDEADBEEF} with drainEn=1 → after t+1, commitVec=1000, writeSelect0=5, writeData0=0xDEADBEEF; count returns to 0.
- Burst and throttle: with drainEn=0, push 4+4+4 entries (tags 1..12) → count=12, inReady=0 at count 13 boundary. Then drainEn=1 → three cycles of commitVec=1111 with tags 1–4, 5–8, 9–12 in order.
- Wrap and concurrent push/pop, DEPTH=16: 40 cycles of random pushVec honouring inReady, drainEn toggled → every tag emitted exactly once, in push order, count matches the scoreboard.
- Overflow: fill to count=16, push pushVec=0001 → entry dropped, overflowErr=1 and stays 1 until reset; queue contents unchanged.
- Filter: with REG_WRITE_P0_FILTER_EN, push tags {0,7,0,9} → count=2, outputs tags 7 then 9. Without the macro → count=4, tags 0,7,0,9.
